bus_sram_slave: RTL and testbench
=================================

Name: bus_sram_slave

Overview:
- Word-addressed on-chip SRAM that responds as a bus slave to burst transactions.
- Sits directly downstream of the JTAG DMA bus master. It consumes the master's begin/data/end bus signals and returns read data, end-of-transaction, busy and error.
- Serves as the target memory for JTAG-initiated reads and writes, and as the slave model for verifying the DMA stage.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^ADDR_WIDTH.
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- address_dataIN  in  32  address in the begin cycle, write data in data beats.
- byte_enableIN  in  4  byte lanes; sampled at begin, applied to every write beat.
- burst_sizeIN  in  8  beats minus 1, sampled at begin (0 = single word).
- read_n_writeIN  in  1  1 = read, 0 = write; sampled at begin.
- begin_transactionIN  in  1  one-cycle start strobe from master.
- end_transactionIN  in  1  master end/abort strobe.
- data_validIN  in  1  write beat valid.
- busyIN  in  1  master cannot accept read data this cycle.
- address_dataOUT  out  32  read data; 0 when not driving (wired-OR bus).
- end_transactionOUT  out  1  one-cycle end strobe after a read or error.
- data_validOUT  out  1  read beat valid.
- busyOUT  out  1  slave stalls write beats.
- errorOUT  out  1  one-cycle error strobe.

Behaviour:
- Reset (reset==0 at edge): all outputs 0, FSM to IDLE, beat counter 0. Memory contents are not cleared. Reset mid-transaction aborts immediately with no end strobe.
- Select: on begin_transactionIN, address_dataIN[31:ADDR_WIDTH+2] must equal BASE_ADDR[31:ADDR_WIDTH+2].
  - Not selected: stay IDLE and drive nothing.
  - Selected: latch word address = address_dataIN[ADDR_WIDTH+1:2], byte_enableIN, burst_sizeIN and read_n_writeIN.
- States: IDLE, READ, WRITE, ERR, END.
- IDLE:
  - Selected begin with address_dataIN[1:0] != 0 -> ERR.
  - Selected, aligned read -> READ.
  - Selected, aligned write -> WRITE.
- ERR: errorOUT=1 for one cycle -> END.
- END: end_transactionOUT=1 for one cycle -> IDLE.
- READ:
  - Memory read is registered. The first data_validOUT appears in the 2nd cycle after the begin cycle.
  - One beat per cycle while busyIN==0. While busyIN==1, hold address_dataOUT and data_validOUT unchanged and do not advance.
  - Word address increments per accepted beat and wraps modulo 2^ADDR_WIDTH.
  - After burst_sizeIN+1 beats are accepted, data_validOUT drops -> END (end strobe the cycle after the last accepted beat).
  - end_transactionIN during READ: abort, outputs to 0 next cycle -> IDLE, no end strobe.
- WRITE:
  - A beat is accepted when data_validIN==1 and busyOUT==0. On acceptance, write address_dataIN to the current word, byte lanes gated by the latched byte_enable.
  - Word address increments and wraps modulo 2^ADDR_WIDTH.
  - Beats beyond burst_sizeIN+1 are ignored (not written).
  - end_transactionIN returns to IDLE, including if it arrives early; the slave issues no end strobe.
  - A beat coinciding with end_transactionIN is still written.
- busyOUT is 0 always unless the optional feature is compiled in.
- begin_transactionIN outside IDLE is ignored.
- A write followed by a read of the same word returns the new data; there is no hazard because accesses are serialized.

Optional Feature:
- BUS_SLAVE_STALL_EN defined:
  - WRITE: busyOUT=1 for one cycle after every 4th accepted beat.
  - READ: an internal bubble withholds data_validOUT for one cycle after every 4th beat.
  - Purpose: exercise master stall handling.
- Undefined: busyOUT tied 0, no bubbles, full-rate bursts.

Test Plan:
- Reset, then single write to 0x0000_0010 with data 0xDEADBEEF, be=4'hF, then single read of 0x10 -> data_validOUT in 2nd cycle after begin with 0xDEADBEEF, end_transactionOUT the following cycle.
- Write 0x11223344 with be=4'b0101 over 0xFFFFFFFF, then read back -> 0xFF22FF44.
- 8-beat read (burst_size=7) starting at word 1020 (default depth) -> data from words 1020..1023 then 0..3 (wrap). busyIN held high on beat 3 for 2 cycles -> beat 3 data held and no beats lost.
- Begin at 0x0000_2000 (outside the 4 KiB window) -> no outputs toggle. Begin at 0x0000_0002 -> errorOUT one cycle, then end_transactionOUT one cycle, memory unchanged.
- 4-beat write ended by end_transactionIN after 2 beats -> only words 0 and 1 written. Reset asserted mid 8-beat read -> all outputs 0 next cycle, no end strobe, prior memory contents intact.
- With BUS_SLAVE_STALL_EN: 8-beat write -> busyOUT high exactly one cycle after beats 4 and 8, all 8 words correct.

Source files
------------

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM bus slave for the JTAG DMA master's begin/data/end burst protocol.
// Optional build macro BUS_SLAVE_STALL_EN: write back-pressure and read bubbles every 4th beat.
module bus_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

`ifdef BUS_SLAVE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ERR,
    S_END
  } state_t;

  logic [31:0]           mem [DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0]            be_q;
  logic [8:0]            rem_q, rem_d;
  logic [1:0]            acc_q, acc_d;
  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  logic                  end_q;
  logic                  err_q;
  logic                  busy_q;

  logic                  sel;
  logic                  aligned;
  logic                  rd_accept;
  logic                  rd_load_ok;
  logic                  rd_bubble;
  logic                  wr_en;

  assign sel     = begin_transactionIN &&
                   (address_dataIN[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign aligned = (address_dataIN[1:0] == 2'b00);

  assign waddr_d = waddr_q + ADDR_WIDTH'(1);
  assign rem_d   = rem_q - 9'd1;
  assign acc_d   = acc_q + 2'd1;

  // The output register is reloaded when empty or when its current beat is taken,
  // so a busy master simply freezes the registered read pipeline.
  assign rd_accept  = rvalid_q && !busyIN;
  assign rd_load_ok = !rvalid_q || !busyIN;
  assign rd_bubble  = STALL_EN && rd_accept && (acc_q == 2'd3) && (rem_q != '0);

  assign wr_en = reset && (state_q == S_WRITE) && data_validIN && !busy_q && (rem_q != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      be_q     <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      end_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          busy_q   <= 1'b0;
          if (sel) begin
            waddr_q <= address_dataIN[TAG_LSB-1:2];
            be_q    <= byte_enableIN;
            rem_q   <= {1'b0, burst_sizeIN} + 9'd1;
            acc_q   <= '0;
            if (!aligned) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (read_n_writeIN) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end

        S_READ: begin
          if (end_transactionIN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            state_q  <= S_IDLE;
          end else if (rd_load_ok) begin
            if (rd_accept) begin
              acc_q <= acc_d;
            end
            if (rem_q == '0) begin
              rvalid_q <= 1'b0;
              rdata_q  <= '0;
              end_q    <= 1'b1;
              state_q  <= S_END;
            end else if (rd_bubble) begin
              rvalid_q <= 1'b0;
              rdata_q  <= '0;
            end else begin
              rdata_q  <= mem[waddr_q];
              rvalid_q <= 1'b1;
              waddr_q  <= waddr_d;
              rem_q    <= rem_d;
            end
          end
        end

        S_WRITE: begin
          busy_q <= 1'b0;
          if (wr_en) begin
            waddr_q <= waddr_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            if (STALL_EN && (acc_q == 2'd3)) begin
              busy_q <= 1'b1;
            end
          end
          if (end_transactionIN) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_ERR: begin
          end_q   <= 1'b1;
          state_q <= S_END;
        end

        S_END: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; contents survive a bus reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[waddr_q][8*b +: 8] <= address_dataIN[8*b +: 8];
        end
      end
    end
  end

  assign address_dataOUT    = rdata_q;
  assign data_validOUT      = rvalid_q;
  assign end_transactionOUT = end_q;
  assign errorOUT           = err_q;
  assign busyOUT            = busy_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: single/burst access, byte lanes, wrap, busy, select, error, abort, reset.
module tb_bus_sram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        errorOUT;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q [$];

  bus_sram_slave #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_WIDTH(10)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .address_dataIN     (address_dataIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .read_n_writeIN     (read_n_writeIN),
    .begin_transactionIN(begin_transactionIN),
    .end_transactionIN  (end_transactionIN),
    .data_validIN       (data_validIN),
    .busyIN             (busyIN),
    .address_dataOUT    (address_dataOUT),
    .end_transactionOUT (end_transactionOUT),
    .data_validOUT      (data_validOUT),
    .busyOUT            (busyOUT),
    .errorOUT           (errorOUT)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {address_dataOUT, data_validOUT, end_transactionOUT, errorOUT, busyOUT};
  endfunction

  task automatic idle_inputs();
    address_dataIN      = '0;
    byte_enableIN       = '0;
    burst_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
  endtask

  task automatic start(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bs,
                       input logic rnw);
    address_dataIN      = addr;
    byte_enableIN       = be;
    burst_sizeIN        = bs;
    read_n_writeIN      = rnw;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
  endtask

  // Presents n beats of base+i; ends either with the last beat or in a separate cycle.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bs,
                             input int n, input logic [31:0] base, input bit end_with_last);
    start(addr, be, bs, 1'b0);
    for (int i = 0; i < n; i++) begin
      data_validIN   = 1'b1;
      address_dataIN = base + 32'(i);
      if (end_with_last && i == n - 1) end_transactionIN = 1'b1;
      for (int g = 0; busyOUT && g < 4; g++) tick();
      tick();
    end
    if (!end_with_last) begin
      data_validIN      = 1'b0;
      end_transactionIN = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  // Expects exp_q[i] on beat i, exact cycle timing; optionally holds busyIN on one beat.
  task automatic read_burst(input logic [31:0] addr, input int n, input int busy_beat,
                            input int busy_cyc);
    start(addr, 4'hF, 8'(n - 1), 1'b1);
    chk("rd_latency_gap", 64'(data_validOUT), 64'd0);
    tick();
    for (int i = 0; i < n; i++) begin
`ifdef BUS_SLAVE_STALL_EN
      if (i > 0 && i % 4 == 0) begin
        chk($sformatf("rd_bubble[%0d]", i), 64'(data_validOUT), 64'd0);
        tick();
      end
`endif
      chk($sformatf("rd_valid[%0d]", i), 64'(data_validOUT), 64'd1);
      chk($sformatf("rd_data[%0d]", i), 64'(address_dataOUT), 64'(exp_q[i]));
      if (i == busy_beat) begin
        busyIN = 1'b1;
        for (int c = 0; c < busy_cyc; c++) begin
          tick();
          if (c == busy_cyc - 1) busyIN = 1'b0;
          chk($sformatf("rd_hold_valid[%0d]", i), 64'(data_validOUT), 64'd1);
          chk($sformatf("rd_hold_data[%0d]", i), 64'(address_dataOUT), 64'(exp_q[i]));
        end
      end
      tick();
    end
    chk("rd_end_strobe", 64'(outs()), 64'h0_0000_0004);
    tick();
    chk("rd_end_drop", 64'(outs()), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 64'(outs()), 64'd0);
    reset = 1'b1;
    tick();
    chk("idle_outputs", 64'(outs()), 64'd0);

    // single write / read
    write_burst(32'h0000_0010, 4'hF, 8'd0, 1, 32'hDEAD_BEEF, 1'b0);
    exp_q = '{32'hDEAD_BEEF};
    read_burst(32'h0000_0010, 1, -1, 0);

    // byte lanes
    write_burst(32'h0000_0020, 4'hF, 8'd0, 1, 32'hFFFF_FFFF, 1'b0);
    write_burst(32'h0000_0020, 4'b0101, 8'd0, 1, 32'h1122_3344, 1'b0);
    exp_q = '{32'hFF22_FF44};
    read_burst(32'h0000_0020, 1, -1, 0);

    // 8-beat write and read across the top of memory, busy on beat 3
    write_burst(32'h0000_0FF0, 4'hF, 8'd7, 8, 32'hA000_0000, 1'b0);
    exp_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
              32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
    read_burst(32'h0000_0FF0, 8, 2, 2);

    // outside the window: nothing responds
    start(32'h0000_2000, 4'hF, 8'd3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("unselected[%0d]", c), 64'(outs()), 64'd0);
      tick();
    end

    // misaligned begin: error then end, no write
    start(32'h0000_0002, 4'hF, 8'd0, 1'b0);
    data_validIN   = 1'b1;
    address_dataIN = 32'h5555_5555;
    chk("err_strobe", 64'(outs()), 64'h0_0000_0002);
    tick();
    chk("err_end_strobe", 64'(outs()), 64'h0_0000_0004);
    tick();
    chk("err_done", 64'(outs()), 64'd0);
    idle_inputs();
    exp_q = '{32'hA000_0004};
    read_burst(32'h0000_0000, 1, -1, 0);

    // 4-beat write ended after 2 beats; later stray beat in IDLE ignored
    write_burst(32'h0000_0000, 4'hF, 8'd3, 2, 32'hC000_0000, 1'b0);
    data_validIN   = 1'b1;
    address_dataIN = 32'h9999_9999;
    tick();
    idle_inputs();
    exp_q = '{32'hC000_0000, 32'hC000_0001, 32'hA000_0006, 32'hA000_0007};
    read_burst(32'h0000_0000, 4, -1, 0);

    // end coinciding with a beat still writes that beat
    write_burst(32'h0000_0FF0, 4'hF, 8'd3, 2, 32'hD000_0000, 1'b1);
    exp_q = '{32'hD000_0000, 32'hD000_0001, 32'hA000_0002};
    read_burst(32'h0000_0FF0, 3, -1, 0);

    // beats beyond burst length are dropped
    write_burst(32'h0000_0034, 4'hF, 8'd0, 1, 32'h1313_1313, 1'b0);
    write_burst(32'h0000_0030, 4'hF, 8'd0, 3, 32'hE000_0000, 1'b0);
    exp_q = '{32'hE000_0000, 32'h1313_1313};
    read_burst(32'h0000_0030, 2, -1, 0);

    // reset in the middle of an 8-beat read
    start(32'h0000_0FF0, 4'hF, 8'd7, 1'b1);
    tick();
    chk("pre_reset_beat0", 64'(address_dataOUT), 64'hD000_0000);
    tick();
    tick();
    chk("pre_reset_beat2", 64'(address_dataOUT), 64'hA000_0002);
    reset = 1'b0;
    tick();
    chk("mid_reset_outputs", 64'(outs()), 64'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_no_end", 64'(outs()), 64'd0);
    tick();
    chk("post_reset_quiet", 64'(outs()), 64'd0);
    exp_q = '{32'hA000_0003};
    read_burst(32'h0000_0FFC, 1, -1, 0);

`ifdef BUS_SLAVE_STALL_EN
    // write stall after every 4th accepted beat
    start(32'h0000_0100, 4'hF, 8'd7, 1'b0);
    for (int i = 0; i < 8; i++) begin
      data_validIN   = 1'b1;
      address_dataIN = 32'hF000_0000 + 32'(i);
      if (i == 4) begin
        chk("wr_stall_after_4", 64'(busyOUT), 64'd1);
        tick();
      end
      chk($sformatf("wr_no_stall[%0d]", i), 64'(busyOUT), 64'd0);
      tick();
    end
    chk("wr_stall_after_8", 64'(busyOUT), 64'd1);
    data_validIN      = 1'b0;
    end_transactionIN = 1'b1;
    tick();
    idle_inputs();
    chk("wr_stall_cleared", 64'(busyOUT), 64'd0);
    exp_q = '{};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hF000_0000 + 32'(i));
    read_burst(32'h0000_0100, 8, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
